// File: rtl/chan_mux_pkg.sv
// Shared definitions for the channel multiplexer: mode encodings and the
// modulo-channel-count increment used by the round-robin pointer.
package chan_mux_pkg;

    localparam logic MODE_FIXED = 1'b0;
    localparam logic MODE_RR    = 1'b1;

    // (v + 1) mod n for v already in [0, n-1]; avoids a divider.
    function automatic int unsigned inc_mod(input int unsigned v, input int unsigned n);
        return (v + 32'd1 >= n) ? 32'd0 : v + 32'd1;
    endfunction

endpackage

// File: rtl/onehot_decoder.sv
// Generalised select decoder: SW-bit index to CH-bit one-hot.
// Indices at or beyond CH have no matching output bit and decode to zero.
module onehot_decoder #(
    parameter int SW = 2,
    parameter int CH = 4
) (
    input  logic [SW-1:0] idx,
    output logic [CH-1:0] oh
);

    genvar gi;
    generate
        for (gi = 0; gi < CH; gi++) begin : g_dec
            assign oh[gi] = (idx == SW'(gi));
        end
    endgenerate

endmodule

// File: rtl/chan_mux_reg.sv
// N-channel W-bit mux with a single-entry registered output and valid/ready
// handshakes; fixed-select or fair round-robin channel selection.
module chan_mux_reg
    import chan_mux_pkg::*;
#(
    parameter int CH = 4,
    parameter int W  = 1,
    parameter int SW = $clog2(CH)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            mode,
    input  logic [SW-1:0]   sel,
    input  logic [CH*W-1:0] d,
    input  logic [CH-1:0]   d_valid,
    output logic [CH-1:0]   d_ready,
    output logic [W-1:0]    o,
    output logic [SW-1:0]   o_ch,
    output logic            o_valid,
    input  logic            o_ready
);

    localparam logic [SW:0] CH_W = (SW + 1)'(CH);

    logic [W-1:0]  o_reg;
    logic [SW-1:0] o_ch_reg;
    logic          o_valid_reg;
    logic [SW-1:0] ptr_reg;

    logic          load_en;
    logic [CH-1:0] sel_oh;
    logic [CH-1:0] grant_oh;
    logic          fix_found;
    logic [SW-1:0] rot_idx [CH];
    logic [CH-1:0] rot_valid;
    logic          rr_found;
    logic [SW-1:0] rr_idx;
    logic          grant_valid;
    logic [SW-1:0] grant_idx;
    logic [W-1:0]  grant_data;
    logic [SW-1:0] ptr_next;

    // Output register is free when empty or being drained this cycle.
    assign load_en = !o_valid_reg || o_ready;

    onehot_decoder #(.SW(SW), .CH(CH)) u_sel_dec (
        .idx (sel),
        .oh  (sel_oh)
    );

    assign fix_found = |(sel_oh & d_valid);

    // Rotated view of d_valid: slot gi corresponds to channel (ptr + gi) mod CH.
    genvar gi;
    generate
        for (gi = 0; gi < CH; gi++) begin : g_rot
            logic [SW:0] sum;
            assign sum           = {1'b0, ptr_reg} + (SW + 1)'(gi);
            assign rot_idx[gi]   = (sum >= CH_W) ? SW'(sum - CH_W) : SW'(sum);
            assign rot_valid[gi] = d_valid[rot_idx[gi]];
        end
    endgenerate

    // Lowest rotated slot wins, giving the first valid channel at or after ptr.
    always_comb begin
        rr_found = 1'b0;
        rr_idx   = ptr_reg;
        for (int k = CH - 1; k >= 0; k--) begin
            if (rot_valid[k]) begin
                rr_found = 1'b1;
                rr_idx   = rot_idx[k];
            end
        end
    end

    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = sel;
        if (mode == MODE_RR) begin
            grant_valid = rr_found;
            grant_idx   = rr_idx;
        end else begin
            grant_valid = fix_found;
            grant_idx   = sel;
        end
    end

    onehot_decoder #(.SW(SW), .CH(CH)) u_grant_dec (
        .idx (grant_idx),
        .oh  (grant_oh)
    );

    assign grant_data = d[grant_idx*W +: W];
    assign d_ready    = grant_oh & {CH{!rst && load_en && grant_valid}};
    assign ptr_next   = SW'(inc_mod(32'(grant_idx), 32'(CH)));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o_reg       <= '0;
            o_ch_reg    <= '0;
            o_valid_reg <= 1'b0;
            ptr_reg     <= '0;
        end else if (load_en) begin
            if (grant_valid) begin
                o_reg       <= grant_data;
                o_ch_reg    <= grant_idx;
                o_valid_reg <= 1'b1;
                // Fixed-mode transfers leave the rotation where it was.
                if (mode == MODE_RR) begin
                    ptr_reg <= ptr_next;
                end
            end else begin
                o_valid_reg <= 1'b0;
            end
        end
    end

    assign o       = o_reg;
    assign o_ch    = o_ch_reg;
    assign o_valid = o_valid_reg;

endmodule

// File: tb/tb_chan_mux_reg.sv
// Scoreboard bench for chan_mux_reg: a CH=4 and a CH=3 instance share one
// stimulus stream; a reference model queues expected outputs, a monitor pops them.
module tb_chan_mux_reg;

    logic        clk;
    logic        rst;
    logic        mode;
    logic [1:0]  sel;
    logic [31:0] d;
    logic [3:0]  d_valid;
    logic        o_ready;

    logic [3:0]  d_ready4;
    logic [7:0]  o4;
    logic [1:0]  o_ch4;
    logic        o_valid4;

    logic [2:0]  d_ready3;
    logic [7:0]  o3;
    logic [1:0]  o_ch3;
    logic        o_valid3;

    int total = 0;
    int bad   = 0;

    bit          mv  [2];
    bit          mvn [2];
    int          ptr [2];
    logic [9:0]  q4 [$];
    logic [9:0]  q3 [$];
    bit          mon_en = 1'b0;

    chan_mux_reg #(.CH(4), .W(8)) u_dut4 (
        .clk     (clk),
        .rst     (rst),
        .mode    (mode),
        .sel     (sel),
        .d       (d),
        .d_valid (d_valid),
        .d_ready (d_ready4),
        .o       (o4),
        .o_ch    (o_ch4),
        .o_valid (o_valid4),
        .o_ready (o_ready)
    );

    chan_mux_reg #(.CH(3), .W(8)) u_dut3 (
        .clk     (clk),
        .rst     (rst),
        .mode    (mode),
        .sel     (sel),
        .d       (d[23:0]),
        .d_valid (d_valid[2:0]),
        .d_ready (d_ready3),
        .o       (o3),
        .o_ch    (o_ch3),
        .o_valid (o_valid3),
        .o_ready (o_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Which channel the rules grant: fixed select, or first valid from ptr onward.
    function automatic void model_grant(input int ch, input bit md, input int s,
                                        input logic [3:0] v, input int p,
                                        output bit found, output int g);
        int i;
        found = 1'b0;
        g     = 0;
        if (!md) begin
            if (s < ch && v[s]) begin
                found = 1'b1;
                g     = s;
            end
        end else begin
            for (int k = 0; k < ch; k++) begin
                i = (p + k) % ch;
                if (!found && v[i]) begin
                    found = 1'b1;
                    g     = i;
                end
            end
        end
    endfunction

    task automatic step(input bit r, input bit md, input logic [1:0] s,
                        input logic [3:0] dv, input bit rdy, input logic [31:0] dat);
        bit          load;
        bit          found;
        int          g;
        int          ch;
        logic [31:0] exp_rdy;
        logic [31:0] act_rdy;
        @(posedge clk);
        #1;
        mv[0] = mvn[0];
        mv[1] = mvn[1];
        rst     = r;
        mode    = md;
        sel     = s;
        d_valid = dv;
        o_ready = rdy;
        d       = dat;
        #1;
        if (r) begin
            q4.delete();
            q3.delete();
            for (int j = 0; j < 2; j++) begin
                mv[j]  = 1'b0;
                mvn[j] = 1'b0;
                ptr[j] = 0;
            end
            chk("rst_valid4", 32'(o_valid4), 32'd0);
            chk("rst_o4", 32'(o4), 32'd0);
            chk("rst_ch4", 32'(o_ch4), 32'd0);
            chk("rst_ready4", 32'(d_ready4), 32'd0);
            chk("rst_valid3", 32'(o_valid3), 32'd0);
            chk("rst_ready3", 32'(d_ready3), 32'd0);
        end else begin
            for (int j = 0; j < 2; j++) begin
                ch   = (j == 0) ? 4 : 3;
                load = !mv[j] || rdy;
                model_grant(ch, md, int'(s), dv, ptr[j], found, g);
                exp_rdy = (load && found) ? (32'd1 << g) : 32'd0;
                act_rdy = (j == 0) ? 32'(d_ready4) : 32'(d_ready3);
                chk((j == 0) ? "d_ready4" : "d_ready3", act_rdy, exp_rdy);
                if (load) begin
                    if (found) begin
                        if (j == 0) q4.push_back({2'(g), dat[g*8 +: 8]});
                        else        q3.push_back({2'(g), dat[g*8 +: 8]});
                        mvn[j] = 1'b1;
                        if (md) ptr[j] = (g + 1) % ch;
                    end else begin
                        mvn[j] = 1'b0;
                    end
                end else begin
                    mvn[j] = mv[j];
                end
            end
        end
    endtask

    // Monitor: whatever the DUT presents must be the oldest expected entry.
    always @(negedge clk) begin
        if (mon_en) begin
            chk("o_valid4", 32'(o_valid4), 32'(mv[0]));
            if (o_valid4) begin
                if (q4.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL empty4: got ch=%0d data=%0h expected nothing", o_ch4, o4);
                end else begin
                    chk("data4", 32'(o4), 32'(q4[0][7:0]));
                    chk("ch4", 32'(o_ch4), 32'(q4[0][9:8]));
                    if (o_ready && !rst) begin
                        $display("xfer dut4 ch=%0d data=%02h", o_ch4, o4);
                        void'(q4.pop_front());
                    end
                end
            end
            chk("o_valid3", 32'(o_valid3), 32'(mv[1]));
            if (o_valid3) begin
                if (q3.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL empty3: got ch=%0d data=%0h expected nothing", o_ch3, o3);
                end else begin
                    chk("data3", 32'(o3), 32'(q3[0][7:0]));
                    chk("ch3", 32'(o_ch3), 32'(q3[0][9:8]));
                    if (o_ready && !rst) begin
                        $display("xfer dut3 ch=%0d data=%02h", o_ch3, o3);
                        void'(q3.pop_front());
                    end
                end
            end
        end
    end

    initial begin
        rst     = 1'b1;
        mode    = 1'b1;
        sel     = 2'd0;
        d       = 32'd0;
        d_valid = 4'hF;
        o_ready = 1'b1;
        for (int j = 0; j < 2; j++) begin
            mv[j]  = 1'b0;
            mvn[j] = 1'b0;
            ptr[j] = 0;
        end

        // Reset held with every channel valid, then first capture is channel 0.
        step(1'b1, 1'b1, 2'd0, 4'hF, 1'b1, $urandom);
        mon_en = 1'b1;
        repeat (2) step(1'b1, 1'b1, 2'd0, 4'hF, 1'b1, $urandom);
        step(1'b0, 1'b1, 2'd0, 4'hF, 1'b1, $urandom);

        // Fixed select of channel 2, then an idle selected channel.
        step(1'b0, 1'b0, 2'd2, 4'b0100, 1'b1, 32'h00A5_0000);
        step(1'b0, 1'b0, 2'd3, 4'b0111, 1'b1, $urandom);

        // Round-robin with all valid, then alternate channels only.
        repeat (8) step(1'b0, 1'b1, 2'd0, 4'hF, 1'b1, $urandom);
        repeat (6) step(1'b0, 1'b1, 2'd0, 4'b1010, 1'b1, $urandom);

        // Load 8'h11 and hold it under backpressure.
        step(1'b0, 1'b0, 2'd1, 4'b0010, 1'b1, 32'h0000_1100);
        repeat (3) step(1'b0, 1'b1, 2'd0, 4'hF, 1'b0, $urandom);
        step(1'b0, 1'b1, 2'd0, 4'hF, 1'b1, $urandom);
        step(1'b0, 1'b1, 2'd0, 4'hF, 1'b1, $urandom);

        // Out-of-range select for the 3-channel instance.
        step(1'b0, 1'b0, 2'd3, 4'hF, 1'b1, $urandom);
        step(1'b0, 1'b0, 2'd3, 4'hF, 1'b1, $urandom);

        // Reset between edges while an output is held.
        step(1'b0, 1'b1, 2'd0, 4'hF, 1'b1, $urandom);
        step(1'b0, 1'b1, 2'd0, 4'hF, 1'b1, $urandom);
        step(1'b1, 1'b1, 2'd0, 4'hF, 1'b1, $urandom);
        step(1'b0, 1'b1, 2'd0, 4'b0110, 1'b1, $urandom);
        step(1'b0, 1'b1, 2'd0, 4'hF, 1'b1, $urandom);

        // Randomised traffic with occasional resets.
        repeat (500) begin
            step(($urandom % 100) == 0, 1'($urandom), 2'($urandom), 4'($urandom),
                 ($urandom % 4) != 0, $urandom);
        end

        repeat (3) step(1'b0, 1'b0, 2'd0, 4'h0, 1'b1, $urandom);
        @(negedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
